// File: rtl/fadd_pkg.sv
// fadd_pkg: shared constants and types for the
// shared binary32 adder scheduler.
package fadd_pkg;

  localparam int FP_W       = 32;
  localparam int FLAG_NAN   = 3;
  localparam int FLAG_OF    = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_PLOST = 0;
  localparam int MAX_REQ    = 16;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  // flip the sign bit when s is set (turns A+B into A-B)
  function automatic logic [FP_W-1:0] neg_if(
    input logic [FP_W-1:0] v,
    input logic            s
  );
    return v ^ {s, {(FP_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fadd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting
// just after ptr and wrapping back to ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // scan ptr+1 .. ptr (mod N), first requester wins
  always_comb begin
    int          j;
    logic        found;
    logic [IW-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/fp_adder.sv
// fp_adder: combinational binary32 adder with
// round-to-nearest-even (ROUNDING_TYPE 0) or truncation.
module fp_adder
  import fadd_pkg::*;
#(
  parameter int         BIT_SIZE      = 32,
  parameter int         ROUNDING_TYPE = 0,
  parameter logic [3:0] FLAG_EN       = 4'hF
) (
  input  logic [BIT_SIZE-1:0] i_a,
  input  logic [BIT_SIZE-1:0] i_b,
  output logic [BIT_SIZE-1:0] o_sum,
  output logic [3:0]          o_flags
);

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_swap, w_eff_sub;
  logic [31:0] w_x, w_y, w_res;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [53:0] w_shw;
  logic [26:0] w_al, w_n0, w_n;
  logic [27:0] w_s;
  logic [9:0]  w_e;
  logic [4:0]  w_lz, w_sh;
  logic [24:0] w_m;
  logic        w_g, w_rs, w_up, w_ovf;
  logic [3:0]  w_fl;

  // align, add, normalise, round, then patch specials
  always_comb begin
    w_a_nan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    w_a_inf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_swap  = i_b[30:0] > i_a[30:0];
    w_x     = w_swap ? i_b : i_a;
    w_y     = w_swap ? i_a : i_b;
    w_ex    = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
    w_ey    = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
    w_mx    = {|w_x[30:23], w_x[22:0]};
    w_my    = {|w_y[30:23], w_y[22:0]};
    w_eff_sub = w_x[31] ^ w_y[31];
    w_d     = w_ex - w_ey;
    w_shw   = {w_my, 3'b000, 27'd0} >> w_d;
    w_al    = (w_d >= 8'd27) ? {26'd0, |w_my}
            : (w_shw[53:27] | {26'd0, |w_shw[26:0]});
    w_s     = w_eff_sub
            ? ({1'b0, w_mx, 3'b000} - {1'b0, w_al})
            : ({1'b0, w_mx, 3'b000} + {1'b0, w_al});
    w_e     = {2'b00, w_ex};
    if (w_s[27]) begin
      w_n0 = w_s[27:1] | {26'd0, w_s[0]};
      w_e  = w_e + 10'd1;
    end else begin
      w_n0 = w_s[26:0];
    end
    w_lz = 5'd27;
    for (int k = 0; k < 27; k++) begin
      if (w_n0[k]) w_lz = 5'(26 - k);
    end
    // never shift below the minimum exponent: yields subnormals
    w_sh = ({5'd0, w_lz} < (w_e - 10'd1))
         ? w_lz : 5'(w_e - 10'd1);
    w_n  = w_n0 << w_sh;
    w_e  = w_e - {5'd0, w_sh};
    w_g  = w_n[2];
    w_rs = |w_n[1:0];
    w_up = (ROUNDING_TYPE == 0) && w_g && (w_rs || w_n[3]);
    w_m  = {1'b0, w_n[26:3]} + {24'd0, w_up};
    if (w_m[24]) begin
      w_m = {1'b0, w_m[24:1]};
      w_e = w_e + 10'd1;
    end
    w_ovf = w_m[23] && (w_e >= 10'd255);
    w_fl  = '0;
    if (w_a_nan || w_b_nan ||
        (w_a_inf && w_b_inf && (i_a[31] ^ i_b[31]))) begin
      w_res           = 32'h7FC0_0000;
      w_fl[FLAG_NAN]  = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_x[31], 8'hFF, 23'd0};
    end else if (w_s == 28'd0) begin
      w_res = {w_x[31] & ~w_eff_sub, 31'd0};
    end else if (w_ovf) begin
      w_res = (ROUNDING_TYPE == 0)
            ? {w_x[31], 8'hFF, 23'd0}
            : {w_x[31], 31'h7F7F_FFFF};
      w_fl[FLAG_OF]    = 1'b1;
      w_fl[FLAG_PLOST] = 1'b1;
    end else begin
      w_res = {w_x[31], w_m[23] ? w_e[7:0] : 8'd0, w_m[22:0]};
      w_fl[FLAG_PLOST] = w_g | w_rs;
    end
    w_fl[FLAG_ZERO] = (w_res[30:0] == 31'd0);
  end

  assign o_sum   = BIT_SIZE'(w_res);
  assign o_flags = w_fl & FLAG_EN;

endmodule

// File: rtl/fadd_sched.sv
// fadd_sched: round-robin time-sharing of one binary32
// adder; S1 holds operands, S2 holds the tagged result.
module fadd_sched
  import fadd_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = $clog2(NUM_REQ),
  parameter int ROUNDING_TYPE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FP_W-1:0]         res_data,
  output logic [ID_W-1:0]         res_id,
  output logic [3:0]              res_flags,
  output logic                    busy
);

  logic [ID_W-1:0]    r_last_ptr;
  logic               r_s1_valid;
  fp_pair_t           r_s1_pair;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_res_valid;
  logic [FP_W-1:0]    r_res_data;
  logic [ID_W-1:0]    r_res_id;
  logic [3:0]         r_res_flags;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_s1_adv;
  logic               w_s1_free;
  logic               w_xfer;
  fp_pair_t           w_pair;
  logic [FP_W-1:0]    w_sum;
  logic [3:0]         w_flags;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_last_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  assign w_s1_adv  = r_s1_valid & (~r_res_valid | res_ready);
  assign w_s1_free = ~r_s1_valid | w_s1_adv;
  assign req_ready = w_grant & {NUM_REQ{w_s1_free & ~rst}};
  assign w_xfer    = |(req_valid & req_ready);

  // steer the granted requester's operands into S1
  always_comb begin
    w_pair = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_pair.a = req_a[i*FP_W +: FP_W];
        w_pair.b = neg_if(req_b[i*FP_W +: FP_W], req_sub[i]);
      end
    end
  end

  // S1: capture on transfer, empty when S2 takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pair  <= '0;
      r_s1_id    <= '0;
      r_last_ptr <= ID_W'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_pair  <= w_pair;
      r_s1_id    <= w_gidx;
      r_last_ptr <= w_gidx;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  fp_adder #(
    .BIT_SIZE      (FP_W),
    .ROUNDING_TYPE (ROUNDING_TYPE),
    .FLAG_EN       (4'hF)
  ) u_add (
    .i_a     (r_s1_pair.a),
    .i_b     (r_s1_pair.b),
    .o_sum   (w_sum),
    .o_flags (w_flags)
  );

  // S2: result register, frozen until downstream accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_flags <= '0;
    end else if (w_s1_adv) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_sum;
      r_res_id    <= r_s1_id;
      r_res_flags <= w_flags;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_flags = r_res_flags;
  assign busy      = r_s1_valid | r_res_valid;

endmodule

// File: tb/tb_fadd_sched.sv
// tb_fadd_sched: directed vectors, expected results
// queued on transfer and checked by a separate monitor.
module tb_fadd_sched;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*32-1:0] req_a = '0;
  logic [NR*32-1:0] req_b = '0;
  logic [NR-1:0] req_sub = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [1:0]    res_id;
  logic [3:0]    res_flags;
  logic          busy;

  always #5 clk = ~clk;

  fadd_sched #(.NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_flags (res_flags),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          xlog[$];
  logic [31:0] exp_d[NR];
  logic [3:0]  exp_f[NR];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic setv(input int i,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic s,
                      input logic [31:0] ed,
                      input logic [3:0] ef);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sub[i] = s;
    exp_d[i] = ed;
    exp_f[i] = ef;
  endtask

  // monitor: pop/compare results, log transfers
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_result: got %h want none",
                     res_data);
          end else begin
            e = sb.pop_front();
            chk("res_data", 64'(res_data), 64'(e.d));
            chk("res_flags", 64'(res_flags), 64'(e.f));
            chk("res_id", 64'(res_id), 64'(e.id));
          end
        end
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            sb.push_back('{exp_d[i], exp_f[i], i});
            xlog.push_back(i);
          end
        end
      end
    end
  end

  task automatic issue(input int i,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       input logic [31:0] ed,
                       input logic [3:0] ef,
                       input bit lat);
    bit got;
    @(posedge clk); #1;
    setv(i, a, b, s, ed, ef);
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) chk("xfer_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("lat_s1", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("lat_s2", 64'(res_valid), 64'd1);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 30) begin
      @(negedge clk); #1;
      c++;
    end
    chk("drain_q", 64'(sb.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_flags", 64'(res_flags), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;

    issue(0, 32'h3F800000, 32'h40000000, 1'b0,
          32'h40400000, 4'h0, 1'b1);
    wait_drain();
    issue(2, 32'h40400000, 32'h3F800000, 1'b1,
          32'h40000000, 4'h0, 1'b0);
    issue(2, 32'h3F800000, 32'h3F800000, 1'b1,
          32'h00000000, 4'h2, 1'b0);
    issue(1, 32'h3F800000, 32'h40000000, 1'b1,
          32'hBF800000, 4'h0, 1'b0);
    issue(0, 32'h3F800000, 32'h33800000, 1'b0,
          32'h3F800000, 4'h1, 1'b0);
    issue(1, 32'h3F800001, 32'h33800000, 1'b0,
          32'h3F800002, 4'h1, 1'b0);
    issue(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
          32'h7F800000, 4'h5, 1'b0);
    issue(3, 32'h7FC00000, 32'h3F800000, 1'b0,
          32'h7FC00000, 4'h8, 1'b0);
    wait_drain();

    @(posedge clk); #1;
    setv(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
    setv(1, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
    setv(2, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'h0);
    setv(3, 32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'h0);
    xlog.delete();
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 2) chk("throughput", 64'(res_valid), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("stream_xfers", 64'(xlog.size()), 64'd12);
    for (int k = 0; k < 8 && k < xlog.size(); k++)
      chk("rr_order", 64'(xlog[k]), 64'(k % 4));
    wait_drain();

    @(posedge clk); #1;
    res_ready = 1'b0;
    xlog.delete();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("stall_ready", 64'(req_ready), 64'd0);
        chk("stall_data", 64'(res_data), 64'h40000000);
        chk("stall_id", 64'(res_id), 64'd0);
      end
    end
    chk("stall_xfers", 64'(xlog.size()), 64'd2);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("refill_grant", 64'(req_ready), 64'h4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_force", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
